// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - stall/flush controller handshake bundle
interface pipe_stall_ctrl_if;
    logic        stallreq_id;
    logic        div_req;
    logic        mem_access;
    logic [4:0]  mem_exccode;
    logic [31:0] cp0_epc;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] exc_pc;
    logic        div_start;
    logic        div_done;

    modport master (
        output stallreq_id, div_req, mem_access, mem_exccode, cp0_epc,
        input  stall, flush, exc_pc, div_start, div_done
    );

    modport slave (
        input  stallreq_id, div_req, mem_access, mem_exccode, cp0_epc,
        output stall, flush, exc_pc, div_start, div_done
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush controller (load-use, divide, SRAM wait, exceptions)
module pipe_stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned SRAM_WAIT  = 2,
    parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380,
    parameter logic [4:0]  EXC_NONE   = 5'h10,
    parameter logic [4:0]  EXC_ERET   = 5'h11
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst,
    pipe_stall_ctrl_if.slave bus
);
    localparam logic [4:0] PAT_LOAD_USE = 5'b00111;
    localparam logic [4:0] PAT_DIV      = 5'b01111;
    localparam logic [4:0] PAT_SRAM     = 5'b11111;
    localparam logic       SRAM_EN      = (SRAM_WAIT > 0);
    localparam logic [5:0] DIV_LOAD     = 6'(DIV_CYCLES - 2);
    localparam logic [2:0] MEM_LOAD     = 3'(SRAM_WAIT - 1);

    typedef enum logic [1:0] {IDLE, DIV_WAIT, DIV_DONE} div_state_e;

    div_state_e state_q, state_d;
    logic [5:0] div_cnt_q, div_cnt_d;
    logic [2:0] mem_cnt_q, mem_cnt_d;
    logic       mem_wait_q, mem_wait_d;

    logic exc, sram_stall, div_stall, start, done;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            mem_cnt_q  <= '0;
            mem_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            mem_cnt_q  <= mem_cnt_d;
            mem_wait_q <= mem_wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        mem_cnt_d  = mem_cnt_q;
        mem_wait_d = mem_wait_q;
        sram_stall = 1'b0;
        div_stall  = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        exc        = (bus.mem_exccode != EXC_NONE);

        // mem_wait with mem_cnt==0 is the release cycle: MEM advances, new access ignored
        if (mem_wait_q) begin
            if (mem_cnt_q != 3'd0) begin
                sram_stall = 1'b1;
                mem_cnt_d  = mem_cnt_q - 3'd1;
            end else begin
                mem_wait_d = 1'b0;
            end
        end else if (bus.mem_access && SRAM_EN) begin
            sram_stall = 1'b1;
            mem_wait_d = 1'b1;
            mem_cnt_d  = MEM_LOAD;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.div_req && !sram_stall) begin
                    start     = 1'b1;
                    div_stall = 1'b1;
                    div_cnt_d = DIV_LOAD;
                    state_d   = DIV_WAIT;
                end
            end
            DIV_WAIT: begin
                div_stall = 1'b1;
                if (div_cnt_q == 6'd0) state_d = DIV_DONE;
                else                   div_cnt_d = div_cnt_q - 6'd1;
            end
            DIV_DONE: begin
                // EXE cannot retire the result while MEM is frozen
                if (!sram_stall) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (exc) begin
            state_d    = IDLE;
            div_cnt_d  = '0;
            mem_wait_d = 1'b0;
            mem_cnt_d  = '0;
        end
    end

    logic quiet;
    assign quiet = cpu_rst || exc;

    assign bus.stall     = quiet ? 5'b0 :
                           ((sram_stall      ? PAT_SRAM     : 5'b0) |
                            (div_stall       ? PAT_DIV      : 5'b0) |
                            (bus.stallreq_id ? PAT_LOAD_USE : 5'b0));
    assign bus.flush     = !cpu_rst && exc;
    assign bus.exc_pc    = (!cpu_rst && exc) ?
                           ((bus.mem_exccode == EXC_ERET) ? bus.cp0_epc : EXC_ENTRY) : 32'b0;
    assign bus.div_start = !quiet && start;
    assign bus.div_done  = !quiet && done;
endmodule
